inst_fetch_if: RTL and testbench
================================

Name: inst_fetch_if

Overview:
- Instruction-fetch / IF-ID stage directly downstream of pc_reg.
- Takes the fetch address and chip enable from pc_reg and runs a req/ack handshake with a variable-latency instruction memory.
- Delivers {pc, inst} to ID through registered outputs, with a one-entry hold buffer for words that return while ID is stalled.
- Raises stallreq_if to CTRL while a fetch is outstanding or the hold buffer is occupied.

Parameters:
- TIMEOUT_CYCLES, 255: ack wait limit, used only with IF_TIMEOUT_EN.
- NOP_INST, 32'h00000000: word injected into ID for bubbles and flushes.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- pc_i  in  32  fetch address from pc_reg.
- ce_i  in  1  fetch enable from pc_reg.
- stall  in  6  CTRL stall vector; bit1 holds IF/ID, bit2 holds ID/EX.
- flush  in  1  CTRL exception flush.
- rom_req  out  1  memory request.
- rom_addr  out  32  memory address.
- rom_ack  in  1  data valid; may be asserted in the same cycle as rom_req (zero-wait).
- rom_data  in  32  fetched word.
- id_pc  out  32  pc to ID.
- id_inst  out  32  instruction to ID.
- stallreq_if  out  1  stall request to CTRL.
- fetch_err  out  1  present only with IF_TIMEOUT_EN.

Behaviour:
- Reset (sync, rst=1): state=FETCH, id_pc=0, id_inst=NOP_INST, hold regs=0, addr_q=0, rom_req=0, stallreq_if=0, fetch_err=0.
- States: FETCH, HOLD, DISCARD.
- FETCH:
  - rom_req=ce_i; rom_addr=pc_i; addr_q<=pc_i every FETCH cycle.
  - rom_ack & stall[1]=0: id_pc<=pc_i, id_inst<=rom_data; stay in FETCH. Zero-wait throughput is 1 instruction/cycle.
  - rom_ack & stall[1]=1: hold_pc<=pc_i, hold_inst<=rom_data; go to HOLD.
  - rom_req & !rom_ack & flush: go to DISCARD.
- HOLD:
  - rom_req=0.
  - When stall[1]=0: id regs<=hold regs; go to FETCH.
- DISCARD:
  - rom_req=1, rom_addr=addr_q; requests are never aborted.
  - On rom_ack: drop the data; go to FETCH.
- stallreq_if = (rom_req & !rom_ack) | (state==HOLD). It must never depend combinationally on stall, so no loop forms through CTRL.
- CTRL maps stallreq_if to stall=6'b000111. pc, IF and ID are held, so a branch_flag from ID persists until pc_reg advances.
- pc_reg advances exactly at the edge that completes a fetch.
- ID register update priority:
  1. flush: id_pc<=0, id_inst<=NOP_INST. HOLD entry is dropped and state goes to FETCH; DISCARD is entered if a request is outstanding.
  2. stall[1]=1 & stall[2]=0: bubble (id_pc<=0, id_inst<=NOP_INST). In FETCH with rom_ack, the word goes to hold regs.
  3. stall[1]=1 & stall[2]=1: hold id regs.
  4. stall[1]=0 with no word available (FETCH, !rom_ack): bubble.
- ce_i=0: no request, stallreq_if=0, ID receives bubbles.
- Flush while in DISCARD: stay in DISCARD.
- Reset mid-fetch: the outstanding request is abandoned. The memory must tolerate a rom_req drop during reset.

Optional Feature:
- Macro IF_TIMEOUT_EN.
- When defined:
  - 8-bit-min counter counts consecutive cycles of rom_req & !rom_ack in FETCH/DISCARD.
  - On reaching TIMEOUT_CYCLES: fetch_err pulses 1 cycle, rom_req drops for 1 cycle, ID gets a bubble, state goes to FETCH, counter clears.
  - Counter also clears on ack, rst and state change.
- When undefined: no fetch_err port, no counter, wait is unbounded.

Decomposition:
- Shared package (defines.v): `InstAddrBus, `InstBus, `RegBus widths; `Stop/`NoStop; `ChipEnable/`ChipDisable; NOP encoding; FSM state encodings (if_state_t: FETCH=2'd0, HOLD=2'd1, DISCARD=2'd2).
- One natural sub-module: if_hold_buf, the 1-entry {pc,inst} holding register with load/consume/clear.

Test Plan:
- Zero-wait ROM (ack=req), pc 0,4,8, stall=0 -> id_inst tracks each word one cycle later, stallreq_if stays 0, no bubbles.
- 3-wait-state ROM at pc=0x10 -> stallreq_if=1 for 3 cycles; ack cycle: stallreq_if=0, id_pc=0x10 next edge.
- Ack at pc=0x20 with stall=6'b000011 for 2 cycles -> state HOLD, stallreq_if=1, ID gets NOP; on release id_pc=0x20, then state FETCH.
- flush on the 2nd wait cycle of a fetch at 0x30, pc_i jumps to 0x20 -> rom_addr stays 0x30 until ack, data dropped, id_inst=NOP, next request uses 0x20.
- rst asserted in HOLD -> next edge id_pc=0, id_inst=0, rom_req=0, state FETCH.
- IF_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives -> fetch_err pulses once after 4 wait cycles, rom_req low 1 cycle, then re-requests the same pc.

Source files
------------

// File: rtl/inst_fetch_if_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_if_pkg
// Shared definitions for the instruction-fetch / IF-ID stage:
//   - bus widths for instruction addresses and instruction words
//   - stall and chip-enable encodings used by CTRL and pc_reg
//   - the NOP encoding used for bubbles
//   - the fetch FSM state encoding
// -----------------------------------------------------------------------------
package inst_fetch_if_pkg;

    localparam int unsigned INST_ADDR_W = 32;   // instruction address bus
    localparam int unsigned INST_W      = 32;   // instruction word bus

    localparam logic STOP        = 1'b1;        // stall bit asserted
    localparam logic NO_STOP     = 1'b0;        // stall bit released
    localparam logic CHIP_ENABLE = 1'b1;        // pc_reg fetch enable

    localparam logic [INST_W-1:0] NOP_ENC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,   // issuing / waiting on a request
        HOLD    = 2'd1,   // word parked in the hold buffer while ID is stalled
        DISCARD = 2'd2    // flushed request still in flight, its data is dropped
    } if_state_t;

endpackage

// File: rtl/inst_fetch_if_hold_buf.sv
// -----------------------------------------------------------------------------
// inst_fetch_if_hold_buf
// One-entry {pc, inst} holding register. Captures a fetched word that
// returned while IF/ID was stalled, so the memory request can complete.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : capture pc_i / inst_i
//   clear_i    : entry consumed or flushed (wins over load_i)
//   pc_i       : pc of the returning word
//   inst_i     : returning instruction word
//   pc_o       : held pc
//   inst_o     : held instruction
//   valid_o    : entry occupied
// -----------------------------------------------------------------------------
import inst_fetch_if_pkg::*;

module inst_fetch_if_hold_buf (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   clear_i,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0]      inst_i,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]      inst_o,
    output logic                   valid_o
);

    logic [INST_ADDR_W-1:0] hold_pc_q;
    logic [INST_W-1:0]      hold_inst_q;
    logic                   valid_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
            valid_q     <= 1'b0;
        end else if (load_i) begin
            hold_pc_q   <= pc_i;
            hold_inst_q <= inst_i;
            valid_q     <= 1'b1;
        end
    end

    assign pc_o    = hold_pc_q;
    assign inst_o  = hold_inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// IF / IF-ID stage downstream of pc_reg. Fetches pc_i from a variable-latency
// instruction memory and presents registered {id_pc, id_inst} to ID.
//
// Memory handshake: rom_req is held high with rom_addr stable until rom_ack;
// a word transfers in any cycle where rom_req & rom_ack are both high
// (rom_ack may rise in the same cycle as rom_req). A request, once issued,
// is never withdrawn except by reset or by the timeout retry.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   pc_i, ce_i   : fetch address / enable from pc_reg
//   stall, flush : CTRL stall vector (bit1 IF/ID, bit2 ID/EX) and flush
//   rom_req, rom_addr, rom_ack, rom_data : instruction memory handshake
//   id_pc, id_inst : registered outputs to ID
//   stallreq_if  : stall request to CTRL
//   fetch_err    : one-cycle timeout pulse (only with IF_TIMEOUT_EN)
//   dbg_state    : current FSM state, for observation
//
// Build option: define IF_TIMEOUT_EN to bound the ack wait to TIMEOUT_CYCLES.
// -----------------------------------------------------------------------------
import inst_fetch_if_pkg::*;

module inst_fetch_if #(
    parameter int unsigned        TIMEOUT_CYCLES = 255,
    parameter logic [INST_W-1:0]  NOP_INST       = NOP_ENC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic                   ce_i,
    input  logic [5:0]             stall,
    input  logic                   flush,
    output logic                   rom_req,
    output logic [INST_ADDR_W-1:0] rom_addr,
    input  logic                   rom_ack,
    input  logic [INST_W-1:0]      rom_data,
    output logic [INST_ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0]      id_inst,
    output logic                   stallreq_if,
`ifdef IF_TIMEOUT_EN
    output logic                   fetch_err,
`endif
    output if_state_t              dbg_state
);

    if_state_t              state_q;
    logic [INST_ADDR_W-1:0] addr_q;
    logic [INST_ADDR_W-1:0] id_pc_q;
    logic [INST_W-1:0]      id_inst_q;

    logic                   req_raw;
    logic                   req_drop;
    logic                   wait_c;
    logic                   ack_c;
    logic                   timeout_hit;
    logic                   stall_if;
    logic                   stall_id;
    logic                   hold_load;
    logic                   hold_clear;
    logic [INST_ADDR_W-1:0] hold_pc;
    logic [INST_W-1:0]      hold_inst;
    logic                   hold_valid;
    logic                   unused_ok;

    assign stall_if = (stall[1] == STOP);
    assign stall_id = (stall[2] != NO_STOP);

    always_comb begin
        req_raw = 1'b0;
        case (state_q)
            FETCH:   req_raw = (ce_i == CHIP_ENABLE);
            DISCARD: req_raw = 1'b1;
            default: req_raw = 1'b0;
        endcase
    end

    // Reset drops the request immediately; the memory tolerates this.
    assign rom_req  = ~rst & ~req_drop & req_raw;
    assign rom_addr = (state_q == DISCARD) ? addr_q : pc_i;
    assign wait_c   = rom_req & ~rom_ack;
    assign ack_c    = rom_req & rom_ack;

    // Built only from state and the memory handshake, never from stall,
    // so CTRL cannot close a combinational loop through this output.
    assign stallreq_if = ~rst & (wait_c | (state_q == HOLD));

`ifdef IF_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive unanswered cycle.
    assign timeout_hit = wait_c & (cnt_q == CNT_LAST);
    // The error cycle also withdraws the request so the memory sees a retry.
    assign req_drop    = err_q;
    assign fetch_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            // FETCH->DISCARD on flush is a state change and restarts the count.
            if (wait_c && !timeout_hit && !(flush && state_q == FETCH)) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign unused_ok = ^{stall[5:3], stall[0], hold_valid};
`else
    logic [31:0] unused_timeout;

    assign timeout_hit    = 1'b0;
    assign req_drop       = 1'b0;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign unused_ok      = ^{stall[5:3], stall[0], hold_valid};
`endif

    // A word that returns while IF/ID is stalled is parked; it is released
    // when the stall lifts or thrown away on flush.
    assign hold_load  = ~timeout_hit & ~flush & (state_q == FETCH) & ack_c & stall_if;
    assign hold_clear = flush | ((state_q == HOLD) & ~stall_if);

    inst_fetch_if_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .pc_i    (pc_i),
        .inst_i  (rom_data),
        .pc_o    (hold_pc),
        .inst_o  (hold_inst),
        .valid_o (hold_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            addr_q    <= '0;
            id_pc_q   <= '0;
            id_inst_q <= NOP_INST;
        end else begin
            if (state_q == FETCH) begin
                addr_q <= pc_i;
            end
            if (timeout_hit) begin
                // Abandon the request and retry the same pc from FETCH.
                state_q   <= FETCH;
                id_pc_q   <= '0;
                id_inst_q <= NOP_INST;
            end else if (flush) begin
                id_pc_q   <= '0;
                id_inst_q <= NOP_INST;
                case (state_q)
                    FETCH:   state_q <= wait_c ? DISCARD : FETCH;
                    DISCARD: state_q <= ack_c ? FETCH : DISCARD;
                    default: state_q <= FETCH;
                endcase
            end else begin
                if (!stall_if) begin
                    case (state_q)
                        FETCH: begin
                            id_pc_q   <= ack_c ? pc_i : '0;
                            id_inst_q <= ack_c ? rom_data : NOP_INST;
                        end
                        HOLD: begin
                            id_pc_q   <= hold_pc;
                            id_inst_q <= hold_inst;
                        end
                        default: begin
                            id_pc_q   <= '0;
                            id_inst_q <= NOP_INST;
                        end
                    endcase
                end else if (!stall_id) begin
                    // IF held but ID advancing: ID must see a bubble.
                    id_pc_q   <= '0;
                    id_inst_q <= NOP_INST;
                end
                case (state_q)
                    FETCH:   if (ack_c && stall_if) state_q <= HOLD;
                    HOLD:    if (!stall_if) state_q <= FETCH;
                    DISCARD: if (ack_c) state_q <= FETCH;
                    default: state_q <= FETCH;
                endcase
            end
        end
    end

    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_inst_fetch_if.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_if
// Self-checking bench for inst_fetch_if. The bench plays pc_reg, CTRL and a
// variable-latency instruction memory. Directed scenarios cover reset,
// zero-wait streaming, wait states, HOLD, flush/DISCARD and reset in HOLD;
// a randomized run checks in-order, loss-free delivery against a queue of
// completed fetches. With IF_TIMEOUT_EN the timeout retry is exercised too.
// -----------------------------------------------------------------------------
module tb_inst_fetch_if;
    import inst_fetch_if_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic [5:0]  stall;
    logic        flush;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        stallreq_if;
    logic        fetch_err;
    if_state_t   dbg_state;

    always #5 clk = ~clk;

`ifdef IF_TIMEOUT_EN
    inst_fetch_if #(.TIMEOUT_CYCLES(4), .NOP_INST(NOP)) dut (
`else
    inst_fetch_if #(.NOP_INST(NOP)) dut (
`endif
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .ce_i        (ce_i),
        .stall       (stall),
        .flush       (flush),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .stallreq_if (stallreq_if),
`ifdef IF_TIMEOUT_EN
        .fetch_err   (fetch_err),
`endif
        .dbg_state   (dbg_state)
    );

`ifndef IF_TIMEOUT_EN
    assign fetch_err = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Memory model: a new request waits mem_lat (or random 0..3) cycles.
    int mem_lat    = 0;
    bit mem_rand   = 1'b0;
    bit mem_busy   = 1'b0;
    int mem_remain = 0;

    // Values sampled in the cycle just before the last clock edge.
    logic        s_req;
    logic        s_ack;
    logic        s_stallreq;
    logic        s_err;
    logic [31:0] s_addr;

    logic [63:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, 16'hC0DE};
    endfunction

    // One clock cycle: drive inputs, answer the memory, sample, clock.
    task automatic cycle(input logic [31:0] pc, input logic ce,
                         input logic [5:0] st, input logic fl);
        pc_i  = pc;
        ce_i  = ce;
        stall = st;
        flush = fl;
        #1;
        rom_ack  = 1'b0;
        rom_data = 32'h0;
        if (rom_req) begin
            if (!mem_busy) begin
                mem_busy   = 1'b1;
                mem_remain = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
            end
            if (mem_remain == 0) begin
                rom_ack  = 1'b1;
                rom_data = mem_word(rom_addr);
            end
        end
        #1;
        s_req      = rom_req;
        s_ack      = rom_ack;
        s_addr     = rom_addr;
        s_stallreq = stallreq_if;
        s_err      = fetch_err;
        @(posedge clk);
        #1;
        if (s_req && s_ack) mem_busy = 1'b0;
        else if (s_req)     mem_remain--;
        else                mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(32'h0, 1'b1, 6'b0, 1'b0);
        rst = 1'b0;
        mem_lat = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(32'h4, 1'b1, 6'b0, 1'b0);
        n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b expected 0", s_req); end
        n_checks++; if (s_stallreq !== 1'b0) begin n_errors++; $display("FAIL reset_stallreq: got %b expected 0", s_stallreq); end
        n_checks++; if (id_pc !== 32'h0) begin n_errors++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
        n_checks++; if (id_inst !== NOP) begin n_errors++; $display("FAIL reset_id_inst: got %h expected %h", id_inst, NOP); end
        n_checks++; if (dbg_state !== FETCH) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, FETCH); end
        n_checks++; if (fetch_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", fetch_err); end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] pc;
        mem_lat = 0;
        for (int k = 0; k < 3; k++) begin
            pc = 32'(k * 4);
            cycle(pc, 1'b1, 6'b0, 1'b0);
            n_checks++; if (s_stallreq !== 1'b0) begin n_errors++; $display("FAIL zw_stallreq: got %b expected 0", s_stallreq); end
            n_checks++; if (id_pc !== pc) begin n_errors++; $display("FAIL zw_id_pc: got %h expected %h", id_pc, pc); end
            n_checks++; if (id_inst !== mem_word(pc)) begin n_errors++; $display("FAIL zw_id_inst: got %h expected %h", id_inst, mem_word(pc)); end
        end
    endtask

    task automatic test_wait_states();
        mem_lat = 3;
        for (int k = 0; k < 3; k++) begin
            cycle(32'h10, 1'b1, 6'b0, 1'b0);
            n_checks++; if (s_stallreq !== 1'b1) begin n_errors++; $display("FAIL ws_stallreq_wait: got %b expected 1", s_stallreq); end
            n_checks++; if (id_pc !== 32'h0 || id_inst !== NOP) begin n_errors++; $display("FAIL ws_bubble: got %h/%h expected 0/%h", id_pc, id_inst, NOP); end
        end
        cycle(32'h10, 1'b1, 6'b0, 1'b0);
        n_checks++; if (s_ack !== 1'b1 || s_stallreq !== 1'b0) begin n_errors++; $display("FAIL ws_ack_cycle: got ack %b stallreq %b expected 1 0", s_ack, s_stallreq); end
        n_checks++; if (id_pc !== 32'h10 || id_inst !== mem_word(32'h10)) begin n_errors++; $display("FAIL ws_id: got %h/%h expected 10/%h", id_pc, id_inst, mem_word(32'h10)); end
        mem_lat = 0;
    endtask

    task automatic test_hold();
        do_reset();
        cycle(32'h20, 1'b1, 6'b000011, 1'b0);
        n_checks++; if (dbg_state !== HOLD) begin n_errors++; $display("FAIL hold_enter: got state %0d expected %0d", dbg_state, HOLD); end
        n_checks++; if (id_pc !== 32'h0 || id_inst !== NOP) begin n_errors++; $display("FAIL hold_bubble: got %h/%h expected 0/%h", id_pc, id_inst, NOP); end
        cycle(32'h24, 1'b1, 6'b000011, 1'b0);
        n_checks++; if (s_req !== 1'b0 || s_stallreq !== 1'b1) begin n_errors++; $display("FAIL hold_req: got req %b stallreq %b expected 0 1", s_req, s_stallreq); end
        cycle(32'h24, 1'b1, 6'b000000, 1'b0);
        n_checks++; if (id_pc !== 32'h20 || id_inst !== mem_word(32'h20)) begin n_errors++; $display("FAIL hold_release: got %h/%h expected 20/%h", id_pc, id_inst, mem_word(32'h20)); end
        n_checks++; if (dbg_state !== FETCH) begin n_errors++; $display("FAIL hold_exit: got state %0d expected %0d", dbg_state, FETCH); end
        cycle(32'h24, 1'b1, 6'b000000, 1'b0);
        n_checks++; if (id_pc !== 32'h24) begin n_errors++; $display("FAIL hold_next: got %h expected 24", id_pc); end
        cycle(32'h28, 1'b1, 6'b000111, 1'b0);
        n_checks++; if (id_pc !== 32'h24 || dbg_state !== HOLD) begin n_errors++; $display("FAIL hold_freeze: got %h state %0d expected 24 state %0d", id_pc, dbg_state, HOLD); end
        cycle(32'h2C, 1'b1, 6'b000000, 1'b0);
        n_checks++; if (id_pc !== 32'h28 || id_inst !== mem_word(32'h28)) begin n_errors++; $display("FAIL hold_freeze_release: got %h/%h expected 28/%h", id_pc, id_inst, mem_word(32'h28)); end
    endtask

    task automatic test_flush();
        do_reset();
        mem_lat = 3;
        cycle(32'h30, 1'b1, 6'b0, 1'b0);
        cycle(32'h30, 1'b1, 6'b0, 1'b1);
        n_checks++; if (dbg_state !== DISCARD) begin n_errors++; $display("FAIL flush_state: got %0d expected %0d", dbg_state, DISCARD); end
        n_checks++; if (id_pc !== 32'h0 || id_inst !== NOP) begin n_errors++; $display("FAIL flush_id: got %h/%h expected 0/%h", id_pc, id_inst, NOP); end
        cycle(32'h20, 1'b1, 6'b0, 1'b0);
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h30) begin n_errors++; $display("FAIL flush_addr_wait: got req %b addr %h expected 1 30", s_req, s_addr); end
        cycle(32'h20, 1'b1, 6'b0, 1'b0);
        n_checks++; if (s_ack !== 1'b1 || s_addr !== 32'h30) begin n_errors++; $display("FAIL flush_addr_ack: got ack %b addr %h expected 1 30", s_ack, s_addr); end
        n_checks++; if (id_inst !== NOP || dbg_state !== FETCH) begin n_errors++; $display("FAIL flush_drop: got %h state %0d expected %h state %0d", id_inst, dbg_state, NOP, FETCH); end
        mem_lat = 0;
        cycle(32'h20, 1'b1, 6'b0, 1'b0);
        n_checks++; if (s_addr !== 32'h20) begin n_errors++; $display("FAIL flush_new_addr: got %h expected 20", s_addr); end
        n_checks++; if (id_pc !== 32'h20 || id_inst !== mem_word(32'h20)) begin n_errors++; $display("FAIL flush_new_id: got %h/%h expected 20/%h", id_pc, id_inst, mem_word(32'h20)); end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        cycle(32'h3C, 1'b1, 6'b0, 1'b0);
        cycle(32'h40, 1'b1, 6'b000111, 1'b0);
        n_checks++; if (dbg_state !== HOLD || id_pc !== 32'h3C) begin n_errors++; $display("FAIL rsth_setup: got state %0d pc %h expected %0d 3c", dbg_state, id_pc, HOLD); end
        rst = 1'b1;
        cycle(32'h44, 1'b1, 6'b0, 1'b0);
        n_checks++; if (s_req !== 1'b0 || s_stallreq !== 1'b0) begin n_errors++; $display("FAIL rsth_req: got req %b stallreq %b expected 0 0", s_req, s_stallreq); end
        n_checks++; if (id_pc !== 32'h0 || id_inst !== 32'h0 || dbg_state !== FETCH) begin n_errors++; $display("FAIL rsth_state: got %h/%h state %0d expected 0/0 state %0d", id_pc, id_inst, dbg_state, FETCH); end
        rst = 1'b0;
        cycle(32'h44, 1'b1, 6'b0, 1'b0);
        n_checks++; if (id_pc !== 32'h44) begin n_errors++; $display("FAIL rsth_resume: got %h expected 44", id_pc); end
    endtask

`ifdef IF_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        mem_lat = 1000;
        for (int k = 0; k < 4; k++) begin
            cycle(32'h50, 1'b1, 6'b0, 1'b0);
            n_checks++; if (s_req !== 1'b1 || s_err !== 1'b0) begin n_errors++; $display("FAIL to_wait: got req %b err %b expected 1 0", s_req, s_err); end
        end
        cycle(32'h50, 1'b1, 6'b0, 1'b0);
        n_checks++; if (s_req !== 1'b0 || s_err !== 1'b1) begin n_errors++; $display("FAIL to_pulse: got req %b err %b expected 0 1", s_req, s_err); end
        n_checks++; if (id_inst !== NOP) begin n_errors++; $display("FAIL to_bubble: got %h expected %h", id_inst, NOP); end
        cycle(32'h50, 1'b1, 6'b0, 1'b0);
        n_checks++; if (s_req !== 1'b1 || s_addr !== 32'h50 || s_err !== 1'b0) begin n_errors++; $display("FAIL to_retry: got req %b addr %h err %b expected 1 50 0", s_req, s_addr, s_err); end
        do_reset();
    endtask
`endif

    // Random stalls, latencies and enable gaps. Every completed fetch is
    // queued; ID must show exactly those words, in order, none lost.
    task automatic test_random();
        logic [31:0] pcm;
        logic [31:0] last_pc;
        logic [63:0] e;
        logic [5:0]  st;
        logic        ce;
        do_reset();
        mem_rand = 1'b1;
        pcm      = 32'h100;
        last_pc  = 32'h0;
        exp_q.delete();
        for (int i = 0; i < 460; i++) begin
            if (i < 400) begin
                case ($urandom_range(0, 3))
                    0, 1:    st = 6'b000000;
                    2:       st = 6'b000011;
                    default: st = 6'b000111;
                endcase
                ce = ($urandom_range(0, 9) != 0);
            end else begin
                st = 6'b000000;
                ce = 1'b0;
            end
            cycle(pcm, ce, st, 1'b0);
            if (s_req && s_ack) begin
                n_checks++; if (s_addr !== pcm) begin n_errors++; $display("FAIL rand_addr: got %h expected %h", s_addr, pcm); end
                exp_q.push_back({pcm, mem_word(pcm)});
                pcm = pcm + 32'd4;
            end
            if (id_pc !== 32'h0 && id_pc !== last_pc) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL rand_extra: got pc %h expected no delivery", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({id_pc, id_inst} !== e) begin n_errors++; $display("FAIL rand_order: got %h/%h expected %h/%h", id_pc, id_inst, e[63:32], e[31:0]); end
                end
                last_pc = id_pc;
            end else if (id_pc === 32'h0) begin
                n_checks++; if (id_inst !== NOP) begin n_errors++; $display("FAIL rand_bubble: got %h expected %h", id_inst, NOP); end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL rand_lost: got %0d undelivered expected 0", exp_q.size()); end
        mem_rand = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        pc_i     = 32'h0;
        ce_i     = 1'b0;
        stall    = 6'b0;
        flush    = 1'b0;
        rom_ack  = 1'b0;
        rom_data = 32'h0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_hold();
        test_flush();
        test_reset_in_hold();
`ifdef IF_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
